// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch stage that reads imem, holds one instruction under valid/ready, and handles redirects and HALT.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_STEP = 4,
    parameter logic [5:0] HALT_OP = 6'd63
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              ready,
    output logic              instr_valid,
    output logic [5:0]        op_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [15:0]       imm,
    output logic [10:0]       func_code,
    output logic [25:0]       target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [31:0] ir;
    logic run;
    logic is_halt;
    // run keeps the first request off the bus until one edge after reset release
    assign imem_req    = run && state == REQ;
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = state == HOLD;
    assign halted      = state == HALT;
    assign is_halt     = op_code == HALT_OP;
    assign op_code     = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign imm         = ir[15:0];
    assign func_code   = ir[10:0];
    assign target      = ir[25:0];
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (redirect) begin
            state_nx = REQ;
            pc_nx    = redirect_pc & ~ADDR_W'(3);
        end else begin
            case (state)
                REQ:     state_nx = run ? WAIT : REQ;
                WAIT:    state_nx = HOLD;
                HOLD: begin
                    state_nx = ready ? (is_halt ? HALT : REQ) : HOLD;
                    pc_nx    = (ready && !is_halt) ? pc + ADDR_W'(PC_STEP) : pc;
                end
                default: state_nx = HALT;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= REQ;
            pc     <= RESET_PC;
            run    <= 1'b0;
            ir     <= '0;
            pc_out <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            run   <= 1'b1;
            if (state == WAIT && !redirect) begin
                ir     <= imem_rdata;
                pc_out <= pc;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scenario bench with a behavioural fetch-order model and a synchronous imem model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, reset = 1'b0, redirect = 1'b0, ready = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, pc_out;
    logic [5:0]  op_code;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [10:0] func_code;
    logic [25:0] target;
    logic        r8_redirect = 1'b0, r8_ready = 1'b0;
    logic [7:0]  r8_rpc = '0;
    logic [31:0] r8_rdata = '0;
    logic        r8_req, r8_valid, r8_halted;
    logic [7:0]  r8_addr, r8_pc_out;
    logic [5:0]  r8_op;
    logic [4:0]  r8_rs, r8_rt;
    logic [15:0] r8_imm;
    logic [10:0] r8_func;
    logic [25:0] r8_target;
    int          vecs = 0, errs = 0;
    logic [31:0] m_pc = '0, seed = '0;
    logic [31:0] ovr [logic [31:0]];
    logic [68:0] got_f;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .ready(ready), .instr_valid(instr_valid),
        .op_code(op_code), .rs(rs), .rt(rt), .imm(imm), .func_code(func_code), .target(target),
        .pc_out(pc_out), .halted(halted)
    );
    instr_fetch_unit #(.ADDR_W(8)) dut8 (
        .clk(clk), .reset(reset), .imem_req(r8_req), .imem_addr(r8_addr), .imem_rdata(r8_rdata),
        .redirect(r8_redirect), .redirect_pc(r8_rpc), .ready(r8_ready), .instr_valid(r8_valid),
        .op_code(r8_op), .rs(r8_rs), .rt(r8_rt), .imm(r8_imm), .func_code(r8_func), .target(r8_target),
        .pc_out(r8_pc_out), .halted(r8_halted)
    );

    assign got_f = {op_code, rs, rt, imm, func_code, target};
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (ovr.exists(a)) return ovr[a];
        w = (a ^ seed) * 32'h9E3779B1;
        if (w[31:26] == 6'd63) w[31:26] = 6'd0;
        return w;
    endfunction

    function automatic logic [68:0] fields_of(input logic [31:0] w);
        return {w[31:26], w[25:21], w[20:16], w[15:0], w[10:0], w[25:0]};
    endfunction

    // memory answers the cycle after a request; junk otherwise so late/early capture shows up
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        vecs++;
        if ({imem_req, imem_addr, instr_valid, halted, got_f, pc_out} !== '0) begin
            errs++;
            $display("FAIL %s got req=%b addr=%h v=%b h=%b f=%h pc=%h exp all 0", name, imem_req, imem_addr,
                     instr_valid, halted, got_f, pc_out);
        end
    endtask

    task automatic do_redirect(input logic [31:0] a, input logic rdy);
        redirect = 1'b1;
        redirect_pc = a;
        ready = rdy;
        tick();
        redirect = 1'b0;
        ready = 1'b0;
        m_pc = a & ~32'd3;
    endtask

    task automatic check_req(input string name);
        int n = 0;
        while (!imem_req && n < 12) begin
            tick();
            n++;
        end
        vecs++;
        if ({imem_req, imem_addr} !== {1'b1, m_pc}) begin
            errs++;
            $display("FAIL %s got req=%b addr=%h exp req=1 addr=%h", name, imem_req, imem_addr, m_pc);
        end
    endtask

    task automatic present(input string name);
        int n = 0;
        while (!instr_valid && n < 12) begin
            tick();
            n++;
        end
        vecs++;
        if ({instr_valid, pc_out, got_f} !== {1'b1, m_pc, fields_of(mem_word(m_pc))}) begin
            errs++;
            $display("FAIL %s got v=%b pc=%h f=%h exp v=1 pc=%h f=%h", name, instr_valid, pc_out, got_f,
                     m_pc, fields_of(mem_word(m_pc)));
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        check_zero("reset_outputs");
        reset = 1'b1;
        ready = 1'b1;
        tick();
        vecs++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errs++;
            $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
        tick();
        vecs++;
        if (instr_valid !== 1'b0) begin
            errs++;
            $display("FAIL early_valid got %b exp 0", instr_valid);
        end
        tick();
        vecs++;
        if ({instr_valid, op_code, func_code, pc_out} !== {1'b1, 6'd0, 11'd0, 32'h0}) begin
            errs++;
            $display("FAIL first_instr got v=%b op=%h fn=%h pc=%h exp v=1 op=0 fn=0 pc=0", instr_valid,
                     op_code, func_code, pc_out);
        end
        tick();
        ready = 1'b0;
        vecs++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h4}) begin
            errs++;
            $display("FAIL second_req got v=%b req=%b addr=%h exp v=0 req=1 addr=4", instr_valid, imem_req,
                     imem_addr);
        end
        m_pc = 32'h4;
    endtask

    task automatic test_backpressure();
        check_req("bp_req");
        present("bp_present");
        vecs++;
        if ({op_code, rs, rt, imm, func_code} !== {6'd1, 5'd1, 5'd2, 16'h1005, 11'h005}) begin
            errs++;
            $display("FAIL bp_fields got op=%h rs=%h rt=%h imm=%h fn=%h exp 01 01 02 1005 005", op_code, rs,
                     rt, imm, func_code);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if ({instr_valid, imem_req, pc_out, got_f} !== {2'b10, 32'h4, fields_of(32'h04221005)}) begin
                errs++;
                $display("FAIL bp_hold got v=%b req=%b pc=%h f=%h exp stable", instr_valid, imem_req, pc_out,
                         got_f);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        m_pc = 32'h8;
        check_req("bp_next_req");
    endtask

    task automatic test_back_to_back();
        do_redirect(32'h1000, 1'b0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if ({imem_req, imem_addr} !== {1'b1, m_pc}) begin
                errs++;
                $display("FAIL b2b_req got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, m_pc);
            end
            repeat (2) tick();
            vecs++;
            if ({instr_valid, pc_out, got_f} !== {1'b1, m_pc, fields_of(mem_word(m_pc))}) begin
                errs++;
                $display("FAIL b2b_valid got v=%b pc=%h f=%h exp v=1 pc=%h", instr_valid, pc_out, got_f, m_pc);
            end
            tick();
            m_pc += 4;
        end
        ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_redirect(32'h20, 1'b0);
        check_req("rw_req");
        tick();
        do_redirect(32'h43, 1'b0);
        vecs++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h40}) begin
            errs++;
            $display("FAIL rw_discard got v=%b req=%b addr=%h exp v=0 req=1 addr=40", instr_valid, imem_req,
                     imem_addr);
        end
        present("rw_present");
    endtask

    task automatic test_redirect_ready();
        do_redirect(32'h10, 1'b0);
        check_req("rr_req");
        present("rr_present");
        do_redirect(32'h100, 1'b1);
        vecs++;
        if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h100}) begin
            errs++;
            $display("FAIL rr_priority got v=%b req=%b addr=%h exp v=0 req=1 addr=100", instr_valid, imem_req,
                     imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_redirect(32'hFFFF_FFFE, 1'b0);
        check_req("wrap_req");
        present("wrap_present");
        ready = 1'b1;
        tick();
        ready = 1'b0;
        m_pc += 4;
        check_req("wrap_next");
    endtask

    task automatic test_random();
        logic [31:0] w;
        do_redirect($urandom, 1'b0);
        for (int k = 0; k < 40; k++) begin
            check_req("rand_req");
            if ($urandom_range(0, 4) == 0) begin
                tick();
                do_redirect($urandom, 1'b0);
                vecs++;
                if (instr_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL rand_discard got v=%b exp 0", instr_valid);
                end
                continue;
            end
            present("rand_present");
            w = mem_word(m_pc);
            repeat ($urandom_range(0, 3)) begin
                tick();
                vecs++;
                if ({instr_valid, imem_req, pc_out, got_f} !== {2'b10, m_pc, fields_of(w)}) begin
                    errs++;
                    $display("FAIL rand_hold got v=%b req=%b pc=%h exp v=1 req=0 pc=%h", instr_valid, imem_req,
                             pc_out, m_pc);
                end
            end
            if ($urandom_range(0, 3) == 0) do_redirect($urandom, 1'b1);
            else begin
                ready = 1'b1;
                tick();
                ready = 1'b0;
                m_pc += 4;
            end
        end
    endtask

    task automatic test_halt();
        ovr[32'h200] = 32'hFC00_0000;
        do_redirect(32'h200, 1'b0);
        check_req("halt_req");
        present("halt_present");
        ready = 1'b1;
        tick();
        ready = 1'b0;
        vecs++;
        if ({halted, instr_valid} !== 2'b10) begin
            errs++;
            $display("FAIL halt_state got h=%b v=%b exp h=1 v=0", halted, instr_valid);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            vecs++;
            if ({imem_req, halted} !== 2'b01) begin
                errs++;
                $display("FAIL halt_idle got req=%b h=%b exp req=0 h=1", imem_req, halted);
            end
        end
        ready = 1'b1;
        do_redirect(32'h0, 1'b0);
        vecs++;
        if ({halted, imem_req, imem_addr} !== {2'b01, 32'h0}) begin
            errs++;
            $display("FAIL halt_resume got h=%b req=%b addr=%h exp h=0 req=1 addr=0", halted, imem_req,
                     imem_addr);
        end
        ovr.delete(32'h200);
    endtask

    task automatic test_reset_mid();
        do_redirect(32'h80, 1'b0);
        check_req("rm_req");
        tick();
        #2 reset = 1'b0;
        #1 check_zero("rm_async");
        tick();
        reset = 1'b1;
        tick();
        m_pc = 32'h0;
        vecs++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errs++;
            $display("FAIL rm_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
        present("rm_present");
    endtask

    task automatic test_addr8();
        r8_redirect = 1'b1;
        r8_rpc = 8'hFD;
        tick();
        r8_redirect = 1'b0;
        vecs++;
        if ({r8_req, r8_addr} !== {1'b1, 8'hFC}) begin
            errs++;
            $display("FAIL a8_req got req=%b addr=%h exp req=1 addr=fc", r8_req, r8_addr);
        end
        repeat (2) tick();
        vecs++;
        if ({r8_valid, r8_pc_out} !== {1'b1, 8'hFC}) begin
            errs++;
            $display("FAIL a8_valid got v=%b pc=%h exp v=1 pc=fc", r8_valid, r8_pc_out);
        end
        r8_ready = 1'b1;
        tick();
        r8_ready = 1'b0;
        vecs++;
        if ({r8_req, r8_addr} !== {1'b1, 8'h00}) begin
            errs++;
            $display("FAIL a8_wrap got req=%b addr=%h exp req=1 addr=00", r8_req, r8_addr);
        end
    endtask

    initial begin
        seed = $urandom;
        ovr[32'h0] = 32'h0;
        ovr[32'h4] = 32'h0422_1005;
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_ready();
        test_wrap();
        test_random();
        test_halt();
        test_reset_mid();
        test_addr8();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
